// File: rtl/pc_fetch_seq.sv
// Program counter and instruction-fetch request stage with queued redirects.
// Optional fetch counter port enabled by defining PC_FETCH_COUNT_EN.
module pc_fetch_seq #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_tgt,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_tgt,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
`ifdef PC_FETCH_COUNT_EN
  output logic [31:0]      fetch_cnt,
`endif
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ISSUE, ERR} state_t;

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  state_t           state;
  logic             pendV;
  logic [WIDTH-1:0] pendA;
  logic [WIDTH-1:0] tgt;
  logic             redir;
  logic             misAligned;

  assign tgt        = jump ? jump_tgt : branch_tgt;
  assign redir      = jump | branch;
  assign misAligned = |(tgt & ALIGN_MASK);
  assign pc_plus    = pc + STEP_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_VEC;
      req_valid <= 1'b0;
      err       <= 1'b0;
      pendV     <= 1'b0;
      pendA     <= '0;
`ifdef PC_FETCH_COUNT_EN
      fetch_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (redir && misAligned) begin
            err       <= 1'b1;
            state     <= ERR;
            req_valid <= 1'b0;
          end else begin
            if (redir) begin
              pc    <= tgt;
              pendV <= 1'b0;
            end
            if (en) begin
              state     <= ISSUE;
              req_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
`ifdef PC_FETCH_COUNT_EN
          if (req_ready) fetch_cnt <= fetch_cnt + 32'd1;
`endif
          // A misaligned redirect still lets a same-cycle accept complete, but pc stays put.
          if (redir && misAligned) begin
            err       <= 1'b1;
            state     <= ERR;
            req_valid <= 1'b0;
          end else if (req_ready) begin
            if (redir)      pc <= tgt;
            else if (pendV) pc <= pendA;
            else            pc <= pc_plus;
            pendV <= 1'b0;
            if (!en) begin
              state     <= IDLE;
              req_valid <= 1'b0;
            end
          end else if (redir) begin
            pendV <= 1'b1;
            pendA <= tgt;
          end
        end
        ERR: begin
          req_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed table-driven bench for pc_fetch_seq plus an 8-bit wrap-around instance.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, en, branch, jump, reqReady;
  logic [31:0] branchTgt, jumpTgt;
  logic        reqValid, err;
  logic [31:0] pc, pcPlus;
`ifdef PC_FETCH_COUNT_EN
  logic [31:0] fetchCnt;
  logic [31:0] wFetchCnt;
`endif

  logic        wRst, wEn, wReady;
  logic [7:0]  wZero;
  logic        wBr, wJp;
  logic        wValid, wErr;
  logic [7:0]  wPc, wPcPlus;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_fetch_seq dut (
    .clk(clk), .rst(rst), .en(en),
    .branch(branch), .branch_tgt(branchTgt),
    .jump(jump), .jump_tgt(jumpTgt),
    .req_valid(reqValid), .req_ready(reqReady),
    .pc(pc), .pc_plus(pcPlus),
`ifdef PC_FETCH_COUNT_EN
    .fetch_cnt(fetchCnt),
`endif
    .err(err)
  );

  pc_fetch_seq #(.WIDTH(8), .RESET_VEC(8'hFC), .STEP(4)) uWrap (
    .clk(clk), .rst(wRst), .en(wEn),
    .branch(wBr), .branch_tgt(wZero),
    .jump(wJp), .jump_tgt(wZero),
    .req_valid(wValid), .req_ready(wReady),
    .pc(wPc), .pc_plus(wPcPlus),
`ifdef PC_FETCH_COUNT_EN
    .fetch_cnt(wFetchCnt),
`endif
    .err(wErr)
  );

  typedef struct {
    logic        rst, en, br;
    logic [31:0] brT;
    logic        jp;
    logic [31:0] jpT;
    logic        rdy;
    logic        eV;
    logic [31:0] ePc;
    logic        eErr;
    logic [31:0] eCnt;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic e, logic b, logic [31:0] bt, logic j,
                              logic [31:0] jt, logic rd, logic ev, logic [31:0] ep,
                              logic ee, logic [31:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.br = b; v.brT = bt; v.jp = j; v.jpT = jt; v.rdy = rd;
    v.eV = ev; v.ePc = ep; v.eErr = ee; v.eCnt = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //               rst en br brT     jp jpT     rdy | v  pc      err cnt
    vecs[0]  = mk(1, 0, 0, 0,      0, 0,      0,  0, 32'h000, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h000, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h004, 0, 1);
    vecs[3]  = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h008, 0, 2);
    vecs[4]  = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h00C, 0, 3);
    // stall with a branch queued mid-stall
    vecs[5]  = mk(0, 1, 0, 0,      0, 0,      0,  1, 32'h00C, 0, 3);
    vecs[6]  = mk(0, 1, 1, 32'h40, 0, 0,      0,  1, 32'h00C, 0, 3);
    vecs[7]  = mk(0, 1, 0, 0,      0, 0,      0,  1, 32'h00C, 0, 3);
    vecs[8]  = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h040, 0, 4);
    vecs[9]  = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h044, 0, 5);
    vecs[10] = mk(0, 1, 1, 32'h100,1, 32'h200,1,  1, 32'h200, 0, 6);
    vecs[11] = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h204, 0, 7);
    // two queued redirects: last one wins
    vecs[12] = mk(0, 1, 1, 32'h80, 0, 0,      0,  1, 32'h204, 0, 7);
    vecs[13] = mk(0, 1, 0, 0,      1, 32'h90, 0,  1, 32'h204, 0, 7);
    vecs[14] = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h090, 0, 8);
    vecs[15] = mk(0, 1, 1, 32'h300,0, 0,      1,  1, 32'h300, 0, 9);
    // en dropped while stalled: one more accept then idle
    vecs[16] = mk(0, 0, 0, 0,      0, 0,      0,  1, 32'h300, 0, 9);
    vecs[17] = mk(0, 0, 0, 0,      0, 0,      0,  1, 32'h300, 0, 9);
    vecs[18] = mk(0, 0, 0, 0,      0, 0,      1,  0, 32'h304, 0, 10);
    vecs[19] = mk(0, 0, 0, 0,      0, 0,      1,  0, 32'h304, 0, 10);
    vecs[20] = mk(0, 0, 0, 0,      1, 32'h400,0,  0, 32'h400, 0, 10);
    vecs[21] = mk(0, 1, 0, 0,      0, 0,      0,  1, 32'h400, 0, 10);
    // misaligned jump, then ignored inputs, then reset
    vecs[22] = mk(0, 1, 0, 0,      1, 32'h13, 0,  0, 32'h400, 1, 10);
    vecs[23] = mk(0, 1, 0, 0,      1, 32'h500,1,  0, 32'h400, 1, 10);
    vecs[24] = mk(1, 0, 0, 0,      0, 0,      0,  0, 32'h000, 0, 0);
    vecs[25] = mk(0, 0, 0, 0,      0, 0,      0,  0, 32'h000, 0, 0);
    // reset mid-request clears the pending slot
    vecs[26] = mk(0, 1, 0, 0,      0, 0,      0,  1, 32'h000, 0, 0);
    vecs[27] = mk(0, 1, 1, 32'h40, 0, 0,      0,  1, 32'h000, 0, 0);
    vecs[28] = mk(1, 1, 0, 0,      0, 0,      0,  0, 32'h000, 0, 0);
    vecs[29] = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h000, 0, 0);
    vecs[30] = mk(0, 1, 0, 0,      0, 0,      1,  1, 32'h004, 0, 1);
    // misaligned branch with ready: accept counted, pc frozen
    vecs[31] = mk(0, 1, 1, 32'h22, 0, 0,      1,  0, 32'h004, 1, 2);
    vecs[32] = mk(1, 0, 0, 0,      0, 0,      0,  0, 32'h000, 0, 0);

    rst = 1'b1; en = 1'b0; branch = 1'b0; jump = 1'b0; reqReady = 1'b0;
    branchTgt = '0; jumpTgt = '0;
    wRst = 1'b1; wEn = 1'b0; wReady = 1'b0; wZero = '0; wBr = 1'b0; wJp = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; en = vecs[i].en;
      branch = vecs[i].br; branchTgt = vecs[i].brT;
      jump = vecs[i].jp; jumpTgt = vecs[i].jpT;
      reqReady = vecs[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("v%0d req_valid", i), {31'b0, reqValid}, {31'b0, vecs[i].eV});
      chk($sformatf("v%0d pc", i), pc, vecs[i].ePc);
      chk($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vecs[i].eErr});
      chk($sformatf("v%0d pc_plus", i), pcPlus, vecs[i].ePc + 32'd4);
`ifdef PC_FETCH_COUNT_EN
      chk($sformatf("v%0d fetch_cnt", i), fetchCnt, vecs[i].eCnt);
`endif
    end

    // 8-bit wrap: RESET_VEC=0xFC advances to 0x00 on accept
    wRst = 1'b1;
    @(posedge clk); #1;
    chk("wrap reset pc", {24'b0, wPc}, 32'hFC);
    chk("wrap reset valid", {31'b0, wValid}, 32'd0);
    chk("wrap pc_plus", {24'b0, wPcPlus}, 32'h00);
    wRst = 1'b0; wEn = 1'b1; wReady = 1'b1;
    @(posedge clk); #1;
    chk("wrap issue valid", {31'b0, wValid}, 32'd1);
    chk("wrap issue pc", {24'b0, wPc}, 32'hFC);
    @(posedge clk); #1;
    chk("wrap pc", {24'b0, wPc}, 32'h00);
    chk("wrap err", {31'b0, wErr}, 32'd0);
`ifdef PC_FETCH_COUNT_EN
    chk("wrap fetch_cnt", wFetchCnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
